// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store initiator.
// Takes one load or store request at a time and drives the data-RAM port.
// Lanes are big-endian: byte offset 0 is bits [31:24] of the RAM word.
// Store data is replicated into every lane and ram_sel_o picks the lanes written.
// A misaligned request skips the RAM and completes one cycle after it is accepted.
module mem_access_ctrl #(
   parameter int ADDR_W      = 32,
   parameter int RAM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   input  logic [2:0]        op_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic              ready_o,
   output logic              done_o,
   output logic              addr_err_o,
   output logic [31:0]       rdata_o,
   output logic              ram_ce_o,
   output logic              ram_we_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [3:0]        ram_sel_o,
   output logic [31:0]       ram_data_o,
   input  logic [31:0]       ram_data_i
);

   localparam int CW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LBU = 3'b001;
   localparam logic [2:0] OP_LH  = 3'b010;
   localparam logic [2:0] OP_LHU = 3'b011;
   localparam logic [2:0] OP_LW  = 3'b100;
   localparam logic [2:0] OP_SB  = 3'b101;
   localparam logic [2:0] OP_SH  = 3'b110;
   localparam logic [2:0] OP_SW  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [2:0]      op_q;
   logic [1:0]      off_q;
   logic [CW-1:0]   cnt_q;

   // Request decode (IDLE side).
   logic            is_store_i, is_byte_i, is_half_i, is_word_i, misalign_i;
   logic [3:0]      sel_i;
   logic [31:0]     wdata_steer;

   // Load-return decode (ACCESS side).
   logic            is_store_q;
   logic            access_last;
   logic [3:0][7:0] lanes;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [31:0]     load_ext;

   assign ready_o    = (state_q == S_IDLE);
   assign is_store_q = op_q[2] & (op_q[1] | op_q[0]);

   // Classify the incoming op by size.
   // Build its lane enables and its replicated store data.
   always_comb begin
      is_store_i  = op_i[2] & (op_i[1] | op_i[0]);
      is_byte_i   = (op_i == OP_LB) || (op_i == OP_LBU) || (op_i == OP_SB);
      is_half_i   = (op_i == OP_LH) || (op_i == OP_LHU) || (op_i == OP_SH);
      is_word_i   = (op_i == OP_LW) || (op_i == OP_SW);
      misalign_i  = (is_half_i & addr_i[0]) | (is_word_i & (addr_i[1:0] != 2'b00));
      sel_i       = 4'b1111;
      wdata_steer = wdata_i;
      if (is_byte_i) begin
         sel_i       = 4'b1000 >> addr_i[1:0];
         wdata_steer = {4{wdata_i[7:0]}};
      end else if (is_half_i) begin
         sel_i       = addr_i[1] ? 4'b0011 : 4'b1100;
         wdata_steer = {2{wdata_i[15:0]}};
      end
   end

   // Extract the addressed lane(s) of the RAM word.
   // Sign- or zero-extend the result according to the latched op.
   assign lanes   = ram_data_i;
   assign ld_byte = lanes[2'd3 - off_q];
   assign ld_half = off_q[1] ? ram_data_i[15:0] : ram_data_i[31:16];

   // Pick the extension for the latched load op.
   always_comb begin
      load_ext = ram_data_i;
      case (op_q)
         OP_LB:   load_ext = {{24{ld_byte[7]}}, ld_byte};
         OP_LBU:  load_ext = {24'h0, ld_byte};
         OP_LH:   load_ext = {{16{ld_half[15]}}, ld_half};
         OP_LHU:  load_ext = {16'h0, ld_half};
         default: load_ext = ram_data_i;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   // Next state.
   // A store spends one cycle in ACCESS.
   // A load stays in ACCESS until the latency counter reaches zero.
   always_comb begin
      state_d     = state_q;
      access_last = is_store_q || (cnt_q == '0);
      case (state_q)
         S_IDLE:   if (req_i) state_d = misalign_i ? S_RESP : S_ACCESS;
         S_ACCESS: if (access_last) state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Registered RAM port, status and load result.
   // ram_sel_o is cleared together with the enables when ACCESS ends.
   // ram_addr_o and ram_data_o keep their last value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_q       <= OP_LB;
         off_q      <= 2'b00;
         cnt_q      <= '0;
         done_o     <= 1'b0;
         addr_err_o <= 1'b0;
         rdata_o    <= 32'h0;
         ram_ce_o   <= 1'b0;
         ram_we_o   <= 1'b0;
         ram_addr_o <= '0;
         ram_sel_o  <= 4'b0000;
         ram_data_o <= 32'h0;
      end else begin
         done_o     <= 1'b0;
         addr_err_o <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req_i) begin
                  op_q  <= op_i;
                  off_q <= addr_i[1:0];
                  if (misalign_i) begin
                     done_o     <= 1'b1;
                     addr_err_o <= 1'b1;
                     if (!is_store_i) rdata_o <= 32'h0;
                  end else begin
                     ram_ce_o   <= 1'b1;
                     ram_we_o   <= is_store_i;
                     ram_addr_o <= {addr_i[ADDR_W-1:2], 2'b00};
                     ram_sel_o  <= sel_i;
                     ram_data_o <= wdata_steer;
                     cnt_q      <= CW'(RAM_LATENCY - 1);
                  end
               end
            end
            S_ACCESS: begin
               if (access_last) begin
                  ram_ce_o  <= 1'b0;
                  ram_we_o  <= 1'b0;
                  ram_sel_o <= 4'b0000;
                  done_o    <= 1'b1;
                  if (!is_store_q) rdata_o <= load_ext;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (RAM_LATENCY=3).
// The bench drives a small byte-lane RAM model from the DUT port.
module tb_mem_access_ctrl;

   localparam int LAT = 3;
   localparam logic [2:0] LB = 3'b000, LBU = 3'b001, LH = 3'b010, LW = 3'b100;
   localparam logic [2:0] SB = 3'b101, SW = 3'b111;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_i = 1'b0;
   logic [2:0]  op_i = 3'b000;
   logic [31:0] addr_i = 32'h0;
   logic [31:0] wdata_i = 32'h0;
   logic        ready_o, done_o, addr_err_o, ram_ce_o, ram_we_o;
   logic [31:0] rdata_o, ram_addr_o, ram_data_o, ram_data_i;
   logic [3:0]  ram_sel_o;

   logic [31:0] mem [16];
   logic        poke = 1'b0;
   logic [3:0]  poke_idx = 4'h0;
   logic [31:0] poke_val = 32'h0;

   int checks = 0;
   int errors = 0;

   mem_access_ctrl #(.ADDR_W(32), .RAM_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .ready_o(ready_o), .done_o(done_o),
      .addr_err_o(addr_err_o), .rdata_o(rdata_o), .ram_ce_o(ram_ce_o),
      .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_sel_o(ram_sel_o),
      .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
   );

   always #5 clk = ~clk;

   assign ram_data_i = mem[ram_addr_o[5:2]];

   // RAM model: bench pokes take priority over lane-masked DUT writes.
   always @(posedge clk) begin
      if (poke) mem[poke_idx] <= poke_val;
      else if (ram_ce_o && ram_we_o)
         for (int b = 0; b < 4; b++)
            if (ram_sel_o[b]) mem[ram_addr_o[5:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke_word(input logic [3:0] idx, input logic [31:0] val);
      poke_idx = idx; poke_val = val; poke = 1'b1;
      tick();
      poke = 1'b0;
   endtask

   task automatic run_load(input string tag, input logic [2:0] op, input logic [31:0] addr,
                           input logic [3:0] exp_sel, input logic [31:0] exp_data);
      req_i = 1'b1; op_i = op; addr_i = addr;
      chk({tag, "_ready"}, 32'(ready_o), 32'd1);
      tick();
      req_i = 1'b0;
      for (int i = 0; i < LAT; i++) begin
         chk({tag, "_ce"}, 32'(ram_ce_o), 32'd1);
         chk({tag, "_we"}, 32'(ram_we_o), 32'd0);
         chk({tag, "_addr"}, ram_addr_o, {addr[31:2], 2'b00});
         chk({tag, "_sel"}, 32'(ram_sel_o), 32'(exp_sel));
         chk({tag, "_early_done"}, 32'(done_o), 32'd0);
         tick();
      end
      chk({tag, "_done"}, 32'(done_o), 32'd1);
      chk({tag, "_err"}, 32'(addr_err_o), 32'd0);
      chk({tag, "_ce_off"}, 32'(ram_ce_o), 32'd0);
      chk({tag, "_rdata"}, rdata_o, exp_data);
      tick();
      chk({tag, "_done_off"}, 32'(done_o), 32'd0);
      chk({tag, "_ready_back"}, 32'(ready_o), 32'd1);
   endtask

   task automatic run_misaligned(input string tag, input logic [2:0] op, input logic [31:0] addr,
                                 input logic [31:0] exp_rdata);
      req_i = 1'b1; op_i = op; addr_i = addr; wdata_i = 32'h5555_AAAA;
      tick();
      req_i = 1'b0;
      chk({tag, "_done"}, 32'(done_o), 32'd1);
      chk({tag, "_err"}, 32'(addr_err_o), 32'd1);
      chk({tag, "_ce"}, 32'(ram_ce_o), 32'd0);
      chk({tag, "_rdata"}, rdata_o, exp_rdata);
      tick();
      chk({tag, "_done_off"}, 32'(done_o), 32'd0);
      chk({tag, "_err_off"}, 32'(addr_err_o), 32'd0);
      chk({tag, "_ce_off"}, 32'(ram_ce_o), 32'd0);
      chk({tag, "_ready"}, 32'(ready_o), 32'd1);
   endtask

   initial begin
      int          acc, dn, wes, st_acc, ce_cnt;
      bit          acc_now, cur_store;
      logic [31:0] last_w;
      logic [32:0] q[$];
      logic [32:0] ent;

      // Reset values before any clock edge.
      #2;
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_err", 32'(addr_err_o), 32'd0);
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_ce", 32'(ram_ce_o), 32'd0);
      chk("rst_we", 32'(ram_we_o), 32'd0);
      chk("rst_addr", ram_addr_o, 32'h0);
      chk("rst_sel", 32'(ram_sel_o), 32'h0);
      chk("rst_wdata", ram_data_o, 32'h0);
      tick(); tick();
      rst = 1'b1;

      // SB to 0x13: lane [7:0] of word 0x10.
      poke_word(4'd4, 32'h1122_3344);
      req_i = 1'b1; op_i = SB; addr_i = 32'h13; wdata_i = 32'h0000_00A5;
      tick();
      req_i = 1'b0;
      chk("sb_ce", 32'(ram_ce_o), 32'd1);
      chk("sb_we", 32'(ram_we_o), 32'd1);
      chk("sb_addr", ram_addr_o, 32'h10);
      chk("sb_sel", 32'(ram_sel_o), 32'b0001);
      chk("sb_data", ram_data_o, 32'hA5A5_A5A5);
      chk("sb_ready", 32'(ready_o), 32'd0);
      chk("sb_early_done", 32'(done_o), 32'd0);
      tick();
      chk("sb_done", 32'(done_o), 32'd1);
      chk("sb_we_off", 32'(ram_we_o), 32'd0);
      chk("sb_ce_off", 32'(ram_ce_o), 32'd0);
      chk("sb_rdata_kept", rdata_o, 32'h0);
      chk("sb_mem", mem[4], 32'h1122_33A5);
      tick();
      chk("sb_done_off", 32'(done_o), 32'd0);
      chk("sb_ready_back", 32'(ready_o), 32'd1);

      // Loads of word 0x128034FF at 0x10.
      poke_word(4'd4, 32'h1280_34FF);
      run_load("lb", LB, 32'h11, 4'b0100, 32'hFFFF_FF80);
      run_load("lbu", LBU, 32'h11, 4'b0100, 32'h0000_0080);
      run_load("lh", LH, 32'h12, 4'b0011, 32'h0000_34FF);
      run_load("lb0", LB, 32'h10, 4'b1000, 32'h0000_0012);

      // LW at 0x20: ce high for exactly 3 cycles, done 4 cycles after accept.
      poke_word(4'd8, 32'hDEAD_BEEF);
      run_load("lw", LW, 32'h20, 4'b1111, 32'hDEAD_BEEF);

      // Misaligned requests. A store keeps rdata_o; a load clears it.
      run_misaligned("sw_mis", SW, 32'h22, 32'hDEAD_BEEF);
      run_misaligned("lh_mis", LH, 32'h23, 32'h0);

      // req_i held high with alternating SW/LW to 0x40.
      acc = 0; dn = 0; wes = 0; st_acc = 0; cur_store = 1'b1; last_w = 32'h0;
      req_i = 1'b1; op_i = SW; addr_i = 32'h40; wdata_i = 32'hA000_0000;
      for (int i = 0; i < 40; i++) begin
         acc_now = ready_o;
         if (acc_now) begin
            acc++;
            if (cur_store) begin
               last_w = wdata_i;
               st_acc++;
            end
            q.push_back({cur_store, last_w});
         end
         tick();
         if (ram_we_o) wes++;
         if (done_o) begin
            dn++;
            if (q.size() > 0) begin
               ent = q.pop_front();
               if (!ent[32]) chk("alt_load_rdata", rdata_o, ent[31:0]);
            end
         end
         if (acc_now) begin
            cur_store = ~cur_store;
            op_i = cur_store ? SW : LW;
            if (cur_store) wdata_i = wdata_i + 32'd1;
         end
      end
      req_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (ram_we_o) wes++;
         if (done_o) dn++;
      end
      chk("alt_accepts", 32'(acc), 32'd10);
      chk("alt_dones", 32'(dn), 32'(acc));
      chk("alt_we_cycles", 32'(wes), 32'd5);
      chk("alt_store_accepts", 32'(st_acc), 32'd5);
      chk("alt_ready", 32'(ready_o), 32'd1);

      // Reset during the second ACCESS cycle of a load.
      req_i = 1'b1; op_i = LW; addr_i = 32'h20;
      tick();
      req_i = 1'b0;
      tick();
      chk("mid_ce_before", 32'(ram_ce_o), 32'd1);
      rst = 1'b0;
      #1;
      chk("mid_ce_async", 32'(ram_ce_o), 32'd0);
      chk("mid_we_async", 32'(ram_we_o), 32'd0);
      chk("mid_ready_async", 32'(ready_o), 32'd1);
      chk("mid_rdata_async", rdata_o, 32'h0);
      tick(); tick();
      rst = 1'b1;
      dn = 0; ce_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (done_o) dn++;
         if (ram_ce_o) ce_cnt++;
      end
      chk("mid_no_done", 32'(dn), 32'd0);
      chk("mid_no_ce", 32'(ce_cnt), 32'd0);
      chk("mid_ready", 32'(ready_o), 32'd1);
      chk("mid_rdata", rdata_o, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Load/store initiator for the MEM stage: accepts one load or store request at a time, drives the data-RAM port (chip enable, write enable, word address, byte select, store data), and returns the extracted, sign- or zero-extended load result. It sits between the MEM pipeline stage and the data RAM. It owns byte-lane steering, misalignment detection and RAM-latency sequencing.

## Interface
- ADDR_W, 32, byte address width
- RAM_LATENCY, 1, cycles the RAM needs with `ram_ce_o` high before `ram_data_i` is valid for a load (≥1)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- req_i  in  1  request strobe; accepted when `req_i & ready_o`
- op_i  in  3  000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW
- addr_i  in  ADDR_W  byte address
- wdata_i  in  32  store data (right-aligned: SB uses [7:0], SH uses [15:0])
- ready_o  out  1  high only in IDLE
- done_o  out  1  one-cycle completion pulse
- addr_err_o  out  1  pulses with `done_o` on a misaligned request
- rdata_o  out  32  load result; valid when `done_o`=1, held until the next `done_o`
- ram_ce_o, ram_we_o  out  1  RAM chip/write enable, active-high
- ram_addr_o  out  ADDR_W  word-aligned address ([1:0]=00)
- ram_sel_o  out  4  byte-lane enables; [3] = bits 31:24
- ram_data_o  out  32  lane-steered store data
- ram_data_i  in  32  RAM read data (combinational from address)

## Operation
- Lanes are big-endian. Offset 00 maps to byte [31:24], 01 to [23:16], 10 to [15:8], 11 to [7:0]. Halfword offset 00 maps to [31:16], 10 to [15:0].
- sel values:
  - Byte: 1000, 0100, 0010, 0001 for offsets 0–3.
  - Halfword: 1100 at offset 0, 0011 at offset 2.
  - Word: 1111.
- Store data is replicated into every lane: byte {4{b}}, halfword {2{h}}, word as given.
- Load extraction: select the addressed lane(s) of the captured word. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Misaligned cases: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]≠00. A misaligned request makes no RAM access (`ram_ce_o` stays 0).
- FSM states and transitions:
  - IDLE: on accepted aligned request, latch op/addr/data, go to ACCESS. On accepted misaligned request, go to RESP with the error flagged.
  - ACCESS: `ram_ce_o`=1 and address/sel held.
    - Store: `ram_we_o`=1 for exactly one cycle, then RESP.
    - Load: `ram_we_o`=0 for RAM_LATENCY cycles (down-counter). `ram_data_i` is captured on the last of these cycles, then RESP.
  - RESP: `done_o`=1, `addr_err_o` per the flag, `rdata_o` updated (loads only), all `ram_*` enables 0, then IDLE.
- `rdata_o` value on completion: 0 for a misaligned load. A store leaves `rdata_o` unchanged.
- `req_i` outside IDLE is ignored; the requester must hold it until it sees `ready_o`.

## Timing
- All `ram_*` and status outputs are registered, except `ready_o`, which is decoded from state.
- Acceptance at edge N:
  - Store: ACCESS in cycle N+1, `done_o` in N+2.
  - Load: ACCESS in cycles N+1..N+RAM_LATENCY, `done_o` in N+RAM_LATENCY+1.
  - Misaligned: `done_o` and `addr_err_o` in N+1.
- Back-to-back: the next request can be accepted in the RESP→IDLE cycle's successor, i.e. the first cycle with `ready_o`=1. Minimum store throughput is one store per 3 cycles.
- Reset values (immediate on `rst`=0, independent of `clk`): state IDLE; `ready_o`=1; `done_o`=`addr_err_o`=0; `rdata_o`=0; `ram_ce_o`=`ram_we_o`=0; `ram_addr_o`=0; `ram_sel_o`=0000; `ram_data_o`=0.
- Reset mid-access: the transaction is dropped, no `done_o` is produced, and `ram_we_o` falls asynchronously.
- Counter wrap: the latency counter reloads to RAM_LATENCY−1 on every entry to ACCESS. RAM_LATENCY=1 means a single ACCESS cycle.

## Test plan
- SB, `addr_i`=0x0000_0013, `wdata_i`=0x0000_00A5 → `ram_addr_o`=0x10, `ram_sel_o`=0001, `ram_data_o`=0xA5A5A5A5, `ram_we_o` high 1 cycle, `done_o` 2 cycles after accept.
- LB from 0x11, RAM word 0x1280_34FF → `rdata_o`=0xFFFF_FF80. LBU from the same address → 0x0000_0080. LH from 0x12 → 0x0000_34FF.
- LW from 0x20 with RAM_LATENCY=3, RAM word 0xDEAD_BEEF → `ram_ce_o` high exactly 3 cycles, `done_o` 4 cycles after accept, `rdata_o`=0xDEADBEEF.
- SW to 0x22 → `addr_err_o`=`done_o`=1 one cycle after accept, `ram_ce_o` never asserted. LH from 0x23 → same response, `rdata_o`=0.
- `req_i` held high with alternating SW/LW ops → each request is accepted only when `ready_o`=1, no request is lost or duplicated, and the `done_o` count matches the accept count.
- Assert `rst`=0 during a load's second ACCESS cycle with RAM_LATENCY=3 → `ram_ce_o` drops with no clock edge, no `done_o`, and after release `ready_o`=1 with `rdata_o`=0.
